// File: rtl/encoder_pkg.sv
// Shared constants and pure helpers for the binary-to-one-hot encoder.
// The helpers work on a fixed maximum-width word; callers slice the low OUT_W bits.
package encoder_pkg;

    localparam int DEF_IN_W  = 2;
    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_W = 1 << MAX_IN_W;

    typedef logic [MAX_OUT_W-1:0] word_t;

    function automatic int out_w(input int in_w);
        return 1 << in_w;
    endfunction

    function automatic word_t onehot(input logic [MAX_IN_W-1:0] idx);
        word_t w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

    function automatic word_t idle(input bit active_low);
        return active_low ? '1 : '0;
    endfunction

endpackage

// File: rtl/encoder_if.sv
// Request/response bundle between the index producer and the encoder.
interface encoder_if #(
    parameter int IN_W = encoder_pkg::DEF_IN_W
) ();
    import encoder_pkg::*;

    localparam int OUT_W = out_w(IN_W);

    logic             en;
    logic             in_valid;
    logic [IN_W-1:0]  a;
    logic [OUT_W-1:0] y;
    logic             out_valid;
    logic [IN_W-1:0]  idx_q;

    modport master (
        output en, in_valid, a,
        input  y, out_valid, idx_q
    );

    modport slave (
        input  en, in_valid, a,
        output y, out_valid, idx_q
    );

endinterface

// File: rtl/encoder_onehot_core.sv
// Combinational index-to-one-hot (or one-cold) decode; no state.
module onehot_core
    import encoder_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [IN_W-1:0]          idx_i,
    output logic [out_w(IN_W)-1:0]   y_o
);
    localparam int OUT_W = out_w(IN_W);

    word_t raw_w;
    // Upper bits of the max-width helper result are never used.
    logic  unused_hi;

    assign raw_w     = onehot(MAX_IN_W'(idx_i));
    assign unused_hi = ^raw_w[MAX_OUT_W-1:OUT_W];
    assign y_o       = ACTIVE_LOW ? ~raw_w[OUT_W-1:0] : raw_w[OUT_W-1:0];

endmodule

// File: rtl/encoder.sv
// Registered binary-to-one-hot encoder: one-cycle latency, valid-qualified,
// with optional one-cold output and hold-last-value behaviour.
module encoder
    import encoder_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit HOLD_LAST  = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    encoder_if.slave  bus
);
    localparam int    OUT_W  = out_w(IN_W);
    localparam word_t IDLE_W = idle(ACTIVE_LOW);
    localparam logic [OUT_W-1:0] IDLE = IDLE_W[OUT_W-1:0];

    logic [OUT_W-1:0] enc;
    logic [OUT_W-1:0] y_d,   y_q;
    logic             vld_d, vld_q;
    logic [IN_W-1:0]  idx_d, idx_q;

    onehot_core #(
        .IN_W       (IN_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_core (
        .idx_i (bus.a),
        .y_o   (enc)
    );

    // Disable wins over valid and over HOLD_LAST; idx only moves on an accepted encode.
    always_comb begin
        y_d   = y_q;
        vld_d = 1'b0;
        idx_d = idx_q;
        if (!bus.en) begin
            y_d = IDLE;
        end else if (bus.in_valid) begin
            y_d   = enc;
            vld_d = 1'b1;
            idx_d = bus.a;
        end else if (!HOLD_LAST) begin
            y_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q   <= IDLE;
            vld_q <= 1'b0;
            idx_q <= '0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = vld_q;
    assign bus.idx_q     = idx_q;

endmodule

// File: tb/tb_encoder.sv
// Directed-vector bench: default, active-low and hold-last encoders driven in lockstep.
module tb_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [1:0] a;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    encoder_if #(.IN_W(2)) bus_d ();
    encoder_if #(.IN_W(2)) bus_al ();
    encoder_if #(.IN_W(2)) bus_hl ();

    assign bus_d.en  = en;  assign bus_d.in_valid  = in_valid;  assign bus_d.a  = a;
    assign bus_al.en = en;  assign bus_al.in_valid = in_valid;  assign bus_al.a = a;
    assign bus_hl.en = en;  assign bus_hl.in_valid = in_valid;  assign bus_hl.a = a;

    encoder #(.IN_W(2), .ACTIVE_LOW(1'b0), .HOLD_LAST(1'b0)) dut_d  (.clk(clk), .rst_n(rst_n), .bus(bus_d));
    encoder #(.IN_W(2), .ACTIVE_LOW(1'b1), .HOLD_LAST(1'b0)) dut_al (.clk(clk), .rst_n(rst_n), .bus(bus_al));
    encoder #(.IN_W(2), .ACTIVE_LOW(1'b0), .HOLD_LAST(1'b1)) dut_hl (.clk(clk), .rst_n(rst_n), .bus(bus_hl));

    logic [1:0] core_idx;
    logic [3:0] core_y;
    onehot_core #(.IN_W(2), .ACTIVE_LOW(1'b0)) u_chk_core (.idx_i(core_idx), .y_o(core_y));

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       vld;
        int         a_up;   // upstream value, truncated to 2 bits when driven
        logic [3:0] y;
        logic       ov;
        logic [1:0] idx;
        logic [3:0] y_al;
        logic [3:0] y_hl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input int up);
        @(negedge clk);
        rst_n    = r;
        en       = e;
        in_valid = v;
        a        = 2'(up);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; a = 2'd3; core_idx = 2'd0;

        //            rst en vld a   y        ov idx  y_al     y_hl
        vecs.push_back('{0, 1, 1, 3, 4'b0000, 0, 0, 4'b1111, 4'b0000});
        vecs.push_back('{0, 1, 1, 3, 4'b0000, 0, 0, 4'b1111, 4'b0000});
        vecs.push_back('{0, 1, 1, 3, 4'b0000, 0, 0, 4'b1111, 4'b0000});
        vecs.push_back('{1, 1, 1, 0, 4'b0001, 1, 0, 4'b1110, 4'b0001});
        vecs.push_back('{1, 1, 1, 1, 4'b0010, 1, 1, 4'b1101, 4'b0010});
        vecs.push_back('{1, 1, 1, 2, 4'b0100, 1, 2, 4'b1011, 4'b0100});
        vecs.push_back('{1, 1, 1, 3, 4'b1000, 1, 3, 4'b0111, 4'b1000});
        vecs.push_back('{1, 1, 1, 4, 4'b0001, 1, 0, 4'b1110, 4'b0001});
        vecs.push_back('{1, 1, 1, 2, 4'b0100, 1, 2, 4'b1011, 4'b0100});
        vecs.push_back('{1, 1, 0, 1, 4'b0000, 0, 2, 4'b1111, 4'b0100});
        vecs.push_back('{1, 1, 0, 3, 4'b0000, 0, 2, 4'b1111, 4'b0100});
        vecs.push_back('{1, 0, 1, 1, 4'b0000, 0, 2, 4'b1111, 4'b0000});
        vecs.push_back('{1, 1, 1, 3, 4'b1000, 1, 3, 4'b0111, 4'b1000});
        vecs.push_back('{0, 1, 1, 3, 4'b0000, 0, 0, 4'b1111, 4'b0000});
        vecs.push_back('{1, 1, 1, 1, 4'b0010, 1, 1, 4'b1101, 4'b0010});
        vecs.push_back('{1, 1, 0, 2, 4'b0000, 0, 1, 4'b1111, 4'b0010});

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].vld, vecs[i].a_up);
            check($sformatf("v%0d.y", i),         32'(bus_d.y),         32'(vecs[i].y));
            check($sformatf("v%0d.out_valid", i), 32'(bus_d.out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d.idx_q", i),     32'(bus_d.idx_q),     32'(vecs[i].idx));
            check($sformatf("v%0d.y_al", i),      32'(bus_al.y),        32'(vecs[i].y_al));
            check($sformatf("v%0d.y_hl", i),      32'(bus_hl.y),        32'(vecs[i].y_hl));
            check($sformatf("v%0d.ov_hl", i),     32'(bus_hl.out_valid), 32'(vecs[i].ov));
        end

        // Hold-last across a long valid gap, then en=0 clears it.
        drive(1, 1, 1, 2);
        check("hold.load", 32'(bus_hl.y), 32'h4);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0);
            check($sformatf("hold.gap%0d", k), 32'(bus_hl.y), 32'h4);
            check($sformatf("hold.ov%0d", k),  32'(bus_hl.out_valid), 32'h0);
        end
        drive(1, 0, 0, 0);
        check("hold.en_off", 32'(bus_hl.y), 32'h0);

        // Outputs must not follow inputs between edges.
        drive(1, 1, 1, 1);
        @(negedge clk);
        a = 2'd3; en = 1'b0; in_valid = 1'b0;
        #2;
        check("nocomb.y",  32'(bus_d.y),         32'h2);
        check("nocomb.ov", 32'(bus_d.out_valid), 32'h1);
        check("nocomb.idx", 32'(bus_d.idx_q),    32'h1);

        // Standalone decode core.
        for (int k = 0; k < 4; k++) begin
            core_idx = 2'(k);
            #1;
            check($sformatf("core%0d", k), 32'(core_y), 32'(1 << k));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // One-hot invariant on the default encoder, sampled away from the edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_d.out_valid === 1'b1) begin
            check("inv.onehot", 32'($onehot(bus_d.y)), 32'h1);
        end
    end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- Registered binary-to-one-hot encoder: converts an IN_W-bit index `a` into a 2**IN_W-bit one-hot word `y`.
- Default configuration is 2 bits in, 4 bits out: a=0→0001, a=1→0010, a=2→0100, a=3→1000.
- Used as a select/strobe generator feeding mux enables and per-lane write strobes in the datapath.
- Single clock domain, one-cycle latency, valid-qualified.

Parameters:
- IN_W, 2, width of index input `a`; output width OUT_W = 2**IN_W (derived, not overridable).
- ACTIVE_LOW, 0, 1 = invert `y` so the selected bit is 0 and all others are 1 (idle/reset value becomes all ones).
- HOLD_LAST, 0, 1 = `y` keeps its last value when no valid input arrives; 0 = `y` returns to idle value.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  block enable; 0 forces idle output on next edge
- in_valid  input  1  qualifies `a` this cycle
- a  input  IN_W  binary index
- y  output  OUT_W  one-hot (or one-cold) encoded word, registered
- out_valid  output  1  `y` holds a freshly encoded value
- idx_q  output  IN_W  registered copy of the index that produced `y`

Behaviour:
- Interface: one clock; reset is synchronous and active-low (`clk`, `rst_n`). Reset is sampled only on the rising edge of `clk`.
- Reset (rst_n=0 at an edge):
  - y = idle value (all 0; all 1 if ACTIVE_LOW=1).
  - out_valid = 0, idx_q = 0.
  - Reset has priority over every other input.
- Normal edge with en=1 and in_valid=1:
  - y <= (1 << a), inverted if ACTIVE_LOW.
  - idx_q <= a, out_valid <= 1.
  - Latency is exactly 1 cycle from input to output.
- Edge with en=1, in_valid=0:
  - out_valid <= 0.
  - y holds if HOLD_LAST=1, else y <= idle value.
  - idx_q holds.
- Edge with en=0:
  - y <= idle value, out_valid <= 0, idx_q holds.
  - This applies regardless of in_valid and HOLD_LAST.
- Invariants:
  - Exactly one bit of y is active whenever out_valid=1; never zero-hot or multi-hot.
  - In the default configuration (ACTIVE_LOW=0, HOLD_LAST=0), y is all-zero when out_valid=0.
- Width rules:
  - `a` is strictly IN_W bits; upstream values wider than IN_W are truncated modulo 2**IN_W before reaching the port. With IN_W=2, an upstream 4 arrives as 0 and yields y=0001.
  - No out-of-range condition exists inside the block.
- Throughput: a new encode can be accepted every cycle; back-to-back valids produce back-to-back outputs.
- Reset mid-stream: any value in flight is discarded; the first output after rst_n returns high appears one cycle after the first accepted input.
- No combinational path from inputs to outputs.

Decomposition:
- Package encoder_pkg:
  - Default IN_W constant.
  - OUT_W derivation function.
  - Pure function onehot(idx) returning the one-hot word.
  - Idle-value function idle(ACTIVE_LOW).
- One combinational sub-module, onehot_core: index in, one-hot out, parameterised by IN_W and ACTIVE_LOW. Reused by the top-level register stage and by the checker in the bench.
- Top-level `encoder` contains only the register stage, enable/valid logic and parameter handling.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with a=3, in_valid=1, en=1 → y=0000, out_valid=0, idx_q=0 throughout.
- Sweep: en=1, in_valid=1, a=0,1,2,3 on consecutive cycles → one cycle later y=0001,0010,0100,1000 back-to-back, out_valid=1 each cycle, idx_q tracks a.
- Wrap: upstream integer 4 driven into 2-bit `a` (arrives as 0) → y=0001, out_valid=1.
- Valid gap: a=2 with valid, then in_valid=0 → y=0100 then 0000 (HOLD_LAST=0), or 0100 held (HOLD_LAST=1); out_valid 1 then 0.
- Enable and active-low: en=0 with a=1, in_valid=1 → y idle, out_valid=0. With ACTIVE_LOW=1 and a=1 → y=1101.
- Mid-stream reset: assert rst_n=0 during a burst a=3 → y=0000 on that edge; after release, a=1 → y=0010 one cycle later.
